// File: rtl/key_pkg.sv
// Key debouncer shared types and 50 MHz timing defaults.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    // 20 ms debounce, 500 ms to first repeat, 100 ms repeat period at 50 MHz
    localparam int DB_CYCLES_50M     = 1000000;
    localparam int HOLD_CYCLES_50M   = 25000000;
    localparam int REPEAT_CYCLES_50M = 5000000;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops to settle metastability on the async input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debouncer.sv
// Pushbutton debouncer with press/release strobes and optional auto-repeat.
// Optional feature macro: KEY_LONG_PRESS_EN (hold/repeat strobes on hold_pulse).
module key_debouncer
    import key_pkg::*;
#(
    parameter int DB_CYCLES     = DB_CYCLES_50M,
    parameter int HOLD_CYCLES   = HOLD_CYCLES_50M,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_50M
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse
);

    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES);

    key_state_t      state, state_next;
    logic [DB_W-1:0] db_cnt;
    logic            key_s;
    logic            db_done;
    logic            press_nxt, release_nxt;

    // Invert ahead of the synchronizer so its reset value of 0 means "not pressed";
    // a key held through reset then pays the full synchronizer latency again.
    sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (~key_n),
        .q     (key_s)
    );

    assign db_done = (db_cnt == DB_MAX);

    // Next-state and strobe decode
    always_comb begin
        state_next  = state;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (key_s) state_next = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!key_s) begin
                    state_next = IDLE;
                end else if (db_done) begin
                    state_next = PRESSED;
                    press_nxt  = 1'b1;
                end
            end
            PRESSED: begin
                if (!key_s) state_next = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (key_s) begin
                    state_next = PRESSED;
                end else if (db_done) begin
                    state_next  = IDLE;
                    release_nxt = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, debounce counter (cleared on any state change, saturating) and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            db_cnt        <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state)
                db_cnt <= '0;
            else if (!db_done && (state == PRESS_WAIT || state == RELEASE_WAIT))
                db_cnt <= db_cnt + 1'b1;
            pressed       <= (state_next == PRESSED) || (state_next == RELEASE_WAIT);
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

`ifdef KEY_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic [REP_W-1:0]  rep_cnt;
    logic              hold_run;

    // Count only while staying in a held state; entry from PRESS_WAIT and any
    // move to IDLE both see hold_run low, so the count restarts on each press
    // and hold never coincides with press/release strobes.
    assign hold_run = ((state == PRESSED) || (state == RELEASE_WAIT)) && (state_next != IDLE);

    // First strobe at HOLD_CYCLES into the hold, then one every REPEAT_CYCLES
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt   <= '0;
            rep_cnt    <= '0;
            hold_pulse <= 1'b0;
        end else if (!hold_run) begin
            hold_cnt   <= '0;
            rep_cnt    <= '0;
            hold_pulse <= 1'b0;
        end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt   <= hold_cnt + 1'b1;
            hold_pulse <= (hold_cnt == HOLD_LAST);
        end else if (rep_cnt == REP_LAST) begin
            rep_cnt    <= '0;
            hold_pulse <= 1'b1;
        end else begin
            rep_cnt    <= rep_cnt + 1'b1;
            hold_pulse <= 1'b0;
        end
    end
`else
    assign hold_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DB=4, HOLD=10, REPEAT=3.
// Edge numbering: edge 0 is the first rising edge that samples the new key_n level.
module tb_key_debouncer;

    logic clk = 1'b0;
    logic rst_n;
    logic key_n;
    logic pressed, press_pulse, release_pulse, hold_pulse;

    int checks = 0;
    int errors = 0;

    key_debouncer #(
        .DB_CYCLES     (4),
        .HOLD_CYCLES   (10),
        .REPEAT_CYCLES (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_n         (key_n),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .hold_pulse    (hold_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge, return at the following falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic hold_exp_press(input int e);
`ifdef KEY_LONG_PRESS_EN
        return (e == 17) || (e == 20) || (e == 23) || (e == 26) || (e == 29);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic hold_exp_rel(input int r);
`ifdef KEY_LONG_PRESS_EN
        return (r == 0) || (r == 3) || (r == 6);
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        rst_n = 1'b0;
        key_n = 1'b1;
        #12;
        chk("rst_pressed", 32'(pressed), 0);
        chk("rst_press",   32'(press_pulse), 0);
        chk("rst_release", 32'(release_pulse), 0);
        chk("rst_hold",    32'(hold_pulse), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();

        // Clean press held long enough for the auto-repeat window
        key_n = 1'b0;
        for (int e = 0; e < 32; e++) begin
            tick();
            chk($sformatf("clean_press_pulse e%0d", e), 32'(press_pulse), 32'(e == 7));
            chk($sformatf("clean_pressed e%0d", e), 32'(pressed), 32'(e >= 7));
            chk($sformatf("clean_release e%0d", e), 32'(release_pulse), 0);
            chk($sformatf("hold e%0d", e), 32'(hold_pulse), 32'(hold_exp_press(e)));
            chk($sformatf("excl e%0d", e),
                32'((32'(press_pulse) + 32'(release_pulse) + 32'(hold_pulse)) <= 1), 1);
        end

        // Clean release
        key_n = 1'b1;
        for (int r = 0; r < 10; r++) begin
            tick();
            chk($sformatf("rel_pulse r%0d", r), 32'(release_pulse), 32'(r == 7));
            chk($sformatf("rel_pressed r%0d", r), 32'(pressed), 32'(r < 7));
            chk($sformatf("rel_press r%0d", r), 32'(press_pulse), 0);
            chk($sformatf("rel_hold r%0d", r), 32'(hold_pulse), 32'(hold_exp_rel(r)));
        end
        repeat (2) tick();

        // Press bounce: low for edges 0..2, high at 3, low from 4
        for (int e = 0; e < 14; e++) begin
            key_n = (e == 3);
            tick();
            chk($sformatf("bounce_press e%0d", e), 32'(press_pulse), 32'(e == 11));
            chk($sformatf("bounce_pressed e%0d", e), 32'(pressed), 32'(e >= 11));
        end

        // Release bounce: high for 2 edges then low again
        for (int r = 0; r < 12; r++) begin
            key_n = (r < 2);
            tick();
            chk($sformatf("rbounce_pressed r%0d", r), 32'(pressed), 1);
            chk($sformatf("rbounce_release r%0d", r), 32'(release_pulse), 0);
            chk($sformatf("rbounce_press r%0d", r), 32'(press_pulse), 0);
        end

        // Reset while held: outputs drop immediately, full latency afterwards
        rst_n = 1'b0;
        #1;
        chk("midrst_pressed", 32'(pressed), 0);
        chk("midrst_press",   32'(press_pulse), 0);
        chk("midrst_release", 32'(release_pulse), 0);
        chk("midrst_hold",    32'(hold_pulse), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            chk($sformatf("rerst_press e%0d", e), 32'(press_pulse), 32'(e == 7));
            chk($sformatf("rerst_pressed e%0d", e), 32'(pressed), 32'(e >= 7));
            chk($sformatf("rerst_release e%0d", e), 32'(release_pulse), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
